uart_cart_loader: RTL and testbench

//   Upstream of the SRAM controller's programming path. Receives a cartridge image over a

---
 rtl/uart_cart_loader.sv | 194 +++++++++++++++++++
 tb/tb_uart_cart_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cart_loader.sv
// UART 8N1 receiver and frame parser that turns a cartridge image stream
// into one SRAM write request per payload byte.
module uart_cart_loader #(
    parameter int CLK_DIV       = 217,
    parameter int ACCESS_CYCLES = 4,
    parameter int TIMEOUT       = 1048576
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_rx,
    output logic        prog_active,
    output logic [20:0] prog_address,
    output logic        prog_wr_en,
    output logic [7:0]  prog_wd,
    output logic        prog_done,
    output logic [2:0]  err_flags
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int ACC_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    // ---------------- receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    rx_state_t        rx_state, rx_next;
    logic             rx_meta, rx_s, rx_prev;
    logic [DIV_W-1:0] rx_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic             stop_wait;
    logic             half_tick, bit_tick;
    logic             byte_valid, framing_err;

    assign half_tick   = (rx_cnt == DIV_W'(CLK_DIV / 2 - 1));
    assign bit_tick    = (rx_cnt == DIV_W'(CLK_DIV - 1));
    assign byte_valid  = (rx_state == RX_STOP) && !stop_wait && bit_tick && rx_s;
    assign framing_err = (rx_state == RX_STOP) && !stop_wait && bit_tick && !rx_s;

    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_s) rx_next = RX_START;
            RX_START: if (half_tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_tick && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                // after a bad stop bit, hold off until the line returns high
                if (stop_wait) begin
                    if (rx_s) rx_next = RX_IDLE;
                end else if (bit_tick && rx_s) begin
                    rx_next = RX_IDLE;
                end
            end
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state  <= RX_IDLE;
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            rx_cnt    <= '0;
            bit_idx   <= '0;
            rx_shift  <= '0;
            stop_wait <= 1'b0;
        end else begin
            rx_state <= rx_next;
            rx_meta  <= uart_rx;
            rx_s     <= rx_meta;
            rx_prev  <= rx_s;
            if (rx_state == RX_IDLE || rx_state != rx_next || bit_tick) rx_cnt <= '0;
            else rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == RX_START) bit_idx <= '0;
            if (rx_state == RX_DATA && bit_tick) begin
                rx_shift <= {rx_s, rx_shift[7:1]};
                bit_idx  <= bit_idx + 1'b1;
            end
            if (rx_state != RX_STOP) stop_wait <= 1'b0;
            else if (framing_err)    stop_wait <= 1'b1;
        end
    end

    // ---------------- frame parser and write engine ----------------
    typedef enum logic [3:0] {
        S_SYNC, S_ADR2, S_ADR1, S_ADR0, S_LEN2, S_LEN1, S_LEN0, S_DATA, S_DONE
    } state_t;
    state_t           state, state_next;
    logic [20:0]      addr;
    logic [23:0]      remaining;
    logic [ACC_W-1:0] acc_cnt;
    logic             gap, buf_full;
    logic [7:0]       buf_data;
    logic [TO_W-1:0]  idle_cnt;
    logic             timeout, byte_in, wr_last, busy;
    logic [1:0]       inflight;
    logic             take, launch_direct, launch_buf, to_buf, overrun;

    assign timeout  = (state != S_SYNC) && (idle_cnt == TO_W'(TIMEOUT - 1));
    assign byte_in  = byte_valid && !timeout;
    assign wr_last  = prog_wr_en && (acc_cnt == ACC_W'(ACCESS_CYCLES - 1));
    assign busy     = prog_wr_en || gap;
    // writes accepted but not yet retired; remaining is only decremented on retire
    assign inflight = {1'b0, prog_wr_en} + {1'b0, buf_full};
    assign take     = byte_in && (state == S_DATA) && (remaining > {22'd0, inflight});

    assign launch_buf    = gap && buf_full && !timeout && (state == S_DATA);
    assign launch_direct = take && !busy;
    assign to_buf        = take && busy && (!buf_full || launch_buf);
    assign overrun       = take && busy && buf_full && !launch_buf;

    assign prog_done   = (state == S_DONE);
    assign prog_active = ((state != S_SYNC) && (state != S_DONE)) || prog_wr_en;

    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = S_SYNC;
        end else begin
            unique case (state)
                S_SYNC: if (byte_in && rx_shift == 8'hA5) state_next = S_ADR2;
                S_ADR2: if (byte_in) state_next = S_ADR1;
                S_ADR1: if (byte_in) state_next = S_ADR0;
                S_ADR0: if (byte_in) state_next = S_LEN2;
                S_LEN2: if (byte_in) state_next = S_LEN1;
                S_LEN1: if (byte_in) state_next = S_LEN0;
                S_LEN0: if (byte_in)
                    state_next = ({remaining[15:0], rx_shift} == 24'd0) ? S_DONE : S_DATA;
                S_DATA: if (wr_last && remaining == 24'd1) state_next = S_DONE;
                S_DONE: state_next = S_SYNC;
                default: state_next = S_SYNC;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_SYNC;
            addr         <= '0;
            remaining    <= '0;
            prog_address <= '0;
            prog_wd      <= '0;
            prog_wr_en   <= 1'b0;
            acc_cnt      <= '0;
            gap          <= 1'b0;
            buf_full     <= 1'b0;
            buf_data     <= '0;
            idle_cnt     <= '0;
            err_flags    <= '0;
        end else begin
            state <= state_next;
            if (state == S_SYNC || byte_valid) idle_cnt <= '0;
            else idle_cnt <= idle_cnt + 1'b1;

            if (byte_in) begin
                case (state)
                    S_ADR2, S_ADR1, S_ADR0: addr <= {addr[12:0], rx_shift};
                    S_LEN2, S_LEN1, S_LEN0: remaining <= {remaining[15:0], rx_shift};
                    default: ;
                endcase
            end
            if (wr_last && state == S_DATA) begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
            end

            if (launch_direct || launch_buf) begin
                prog_wr_en   <= 1'b1;
                acc_cnt      <= '0;
                gap          <= 1'b0;
                prog_address <= addr;
                prog_wd      <= launch_buf ? buf_data : rx_shift;
            end else if (wr_last) begin
                prog_wr_en <= 1'b0;
                gap        <= 1'b1;
            end else begin
                if (prog_wr_en) acc_cnt <= acc_cnt + 1'b1;
                gap <= 1'b0;
            end

            if (timeout) begin
                buf_full <= 1'b0;
            end else if (to_buf) begin
                buf_full <= 1'b1;
                buf_data <= rx_shift;
            end else if (launch_buf) begin
                buf_full <= 1'b0;
            end

            if (overrun)     err_flags[2] <= 1'b1;
            if (timeout)     err_flags[1] <= 1'b1;
            if (framing_err) err_flags[0] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_cart_loader.sv
// Directed + randomized bench for uart_cart_loader; expected writes come from
// a frame-level model (address + index mod 2^21) built alongside the stimulus.
`timescale 1ns/1ps
module tb_uart_cart_loader;
    localparam int CLK_DIV = 8;
    localparam int ACC     = 4;
    localparam int TMO     = 2000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        uart_rx = 1'b1;
    logic        prog_active;
    logic [20:0] prog_address;
    logic        prog_wr_en;
    logic [7:0]  prog_wd;
    logic        prog_done;
    logic [2:0]  err_flags;

    uart_cart_loader #(.CLK_DIV(CLK_DIV), .ACCESS_CYCLES(ACC), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .uart_rx(uart_rx),
        .prog_active(prog_active), .prog_address(prog_address),
        .prog_wr_en(prog_wr_en), .prog_wd(prog_wd),
        .prog_done(prog_done), .err_flags(err_flags)
    );

    always #5 clock = ~clock;

    logic [28:0] got_q[$];
    logic [28:0] exp_q[$];
    logic [7:0]  tx_q[$];
    int          done_cnt = 0, exp_done = 0;
    int          bad_len = 0, bad_stable = 0, bad_active = 0, hi_len = 0;
    int          passed = 0, total = 0;
    logic        prev_wr = 1'b0;
    logic [20:0] lat_addr = '0;
    logic [7:0]  lat_wd = '0;

    // Observe the write port: log launches, pulse widths, stability and done pulses.
    always @(negedge clock) begin
        if (reset) begin
            hi_len  = 0;
            prev_wr = 1'b0;
        end else begin
            if (prog_wr_en && !prev_wr) begin
                got_q.push_back({prog_address, prog_wd});
                lat_addr = prog_address;
                lat_wd   = prog_wd;
                hi_len   = 1;
            end else if (prog_wr_en) begin
                hi_len++;
                if (prog_address !== lat_addr || prog_wd !== lat_wd) bad_stable++;
            end else if (prev_wr) begin
                if (hi_len != ACC) bad_len++;
                if (prog_address !== lat_addr || prog_wd !== lat_wd) bad_stable++;
            end
            if (prog_wr_en && !prog_active) bad_active++;
            if (prog_done) done_cnt++;
            prev_wr = prog_wr_en;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CLK_DIV) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CLK_DIV) @(negedge clock);
        end
        uart_rx = stop;
        repeat (CLK_DIV) @(negedge clock);
        uart_rx = 1'b1;
    endtask

    task automatic send_tx();
        while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
    endtask

    task automatic start_test();
        got_q.delete();
        exp_q.delete();
        tx_q.delete();
        done_cnt = 0; exp_done = 0;
        bad_len = 0; bad_stable = 0; bad_active = 0;
    endtask

    // Reference model: a frame writes data[i] to (ADDR + i) mod 2^21.
    task automatic add_frame(input logic [23:0] a, input int n);
        logic [7:0]  d;
        logic [20:0] wa;
        logic [23:0] len;
        len = 24'(n);
        tx_q.push_back(8'hA5);
        tx_q.push_back(a[23:16]); tx_q.push_back(a[15:8]); tx_q.push_back(a[7:0]);
        tx_q.push_back(len[23:16]); tx_q.push_back(len[15:8]); tx_q.push_back(len[7:0]);
        for (int i = 0; i < n; i++) begin
            d  = 8'($urandom);
            wa = 21'((int'(a) + i) % 2097152);
            tx_q.push_back(d);
            exp_q.push_back({wa, d});
        end
        exp_done++;
    endtask

    task automatic check_writes(input string tag);
        chk({tag, " write count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, " write addr/data"}, got_q[i], exp_q[i]);
        chk({tag, " done pulses"}, done_cnt, exp_done);
        chk({tag, " wr_en width"}, bad_len, 0);
        chk({tag, " addr/wd stable"}, bad_stable, 0);
        chk({tag, " active during wr"}, bad_active, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " prog_active"}, prog_active, 0);
        chk({tag, " prog_address"}, prog_address, 0);
        chk({tag, " prog_wr_en"}, prog_wr_en, 0);
        chk({tag, " prog_wd"}, prog_wd, 0);
        chk({tag, " prog_done"}, prog_done, 0);
        chk({tag, " err_flags"}, err_flags, 0);
    endtask

    initial begin
        logic [7:0] g;
        repeat (4) @(negedge clock);
        chk_reset_outputs("reset");
        reset = 1'b0;
        idle(10);

        // 1: basic two-byte frame
        start_test();
        send_byte(8'hA5, 1'b1);
        chk("t1 active after sync", prog_active, 1);
        tx_q = '{8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 8'h02, 8'hAA, 8'h55};
        exp_q = '{{21'h01234, 8'hAA}, {21'h01235, 8'h55}};
        exp_done = 1;
        send_tx();
        idle(30);
        check_writes("t1");
        chk("t1 active end", prog_active, 0);
        chk("t1 err", err_flags, 0);

        // 2: junk before sync, address wrap
        start_test();
        tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h1F, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h02, 8'h11, 8'h22};
        exp_q = '{{21'h1FFFFF, 8'h11}, {21'h000000, 8'h22}};
        exp_done = 1;
        send_tx();
        idle(30);
        check_writes("t2");
        chk("t2 err", err_flags, 0);

        // 3: zero-length frame
        start_test();
        tx_q = '{8'hA5, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
        exp_done = 1;
        send_tx();
        idle(30);
        check_writes("t3");
        chk("t3 active end", prog_active, 0);

        // randomized frames with junk prefixes, first one forced across the wrap
        for (int f = 0; f < 3; f++) begin
            start_test();
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h5A;
                tx_q.push_back(g);
            end
            if (f == 0) add_frame({3'($urandom), 21'h1FFFFE}, 4);
            else add_frame(24'($urandom), int'($urandom_range(1, 4)));
            send_tx();
            idle(30);
            check_writes("rand");
            chk("rand err", err_flags, 0);
        end

        // 4: framing error on a would-be sync byte, then a short low glitch
        start_test();
        send_byte(8'hA5, 1'b0);
        idle(20);
        uart_rx = 1'b0;
        idle(3);
        uart_rx = 1'b1;
        idle(20);
        chk("t4 err", err_flags, 3'b001);
        chk("t4 still sync", prog_active, 0);
        chk("t4 no done", done_cnt, 0);
        add_frame(24'($urandom), 2);
        send_tx();
        idle(30);
        check_writes("t4 after glitch");
        chk("t4 err sticky", err_flags, 3'b001);

        // 5: truncated frame times out
        start_test();
        tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h01};
        exp_q = '{{21'h00000, 8'h01}};
        send_tx();
        idle(1500);
        chk("t5 active before timeout", prog_active, 1);
        chk("t5 err before timeout", err_flags, 3'b001);
        idle(600);
        check_writes("t5");
        chk("t5 active after timeout", prog_active, 0);
        chk("t5 err", err_flags, 3'b011);
        start_test();
        add_frame(24'($urandom), 3);
        send_tx();
        idle(30);
        check_writes("t5 next frame");
        chk("t5 err sticky", err_flags, 3'b011);

        // 6: reset during an active write
        start_test();
        tx_q = '{8'hA5, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h03, 8'h5A};
        send_tx();
        for (int n = 0; n < 20 && !prog_wr_en; n++) @(negedge clock);
        chk("t6 wr_en before reset", prog_wr_en, 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk_reset_outputs("t6 reset");
        idle(2);
        reset = 1'b0;
        idle(5);
        start_test();
        add_frame(24'($urandom), 2);
        send_tx();
        idle(30);
        check_writes("t6 after reset");
        chk("t6 err", err_flags, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
